// File: rtl/mem_responder_if.sv
// Request/response bundle between a cache controller (master) and mem_responder (slave).
interface mem_responder_if;
  logic        cs_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ack_o;
  logic [1:0]  resp_state;

  modport master (
    output cs_i, we_i, addr_i, data_i,
    input  data_o, ack_o, resp_state
  );

  modport slave (
    input  cs_i, we_i, addr_i, data_i,
    output data_o, ack_o, resp_state
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed backing memory that answers each accepted request with a one-cycle ack
// LATENCY cycles later; the ack cycle can accept the next request for gapless bursts.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [3:0]              count_q;
  logic [ADDR_WIDTH-1:0]   wordIdx_q;
  logic                    isWrite_q;
  logic                    ack_q;
  logic [31:0]             data_q;

  logic [31:0]             memArray [DEPTH];
  logic [ADDR_WIDTH-1:0]   wordIdx_d;
  logic                    acceptReq;
  logic                    unusedAddrBits;

  assign wordIdx_d      = bus.addr_i[ADDR_WIDTH+1:2];
  assign unusedAddrBits = ^{bus.addr_i[31:ADDR_WIDTH+2], bus.addr_i[1:0]};

  // rst gates the write so a strobe held during reset cannot touch the array.
  assign acceptReq = rst && bus.cs_i && (state_q == ST_IDLE || state_q == ST_ACK);

  always_ff @(posedge clk) begin
    if (acceptReq && bus.we_i) begin
      memArray[wordIdx_d] <= bus.data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      count_q   <= 4'd0;
      wordIdx_q <= '0;
      isWrite_q <= 1'b0;
      ack_q     <= 1'b0;
      data_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE, ST_ACK: begin
          if (bus.cs_i) begin
            wordIdx_q <= wordIdx_d;
            isWrite_q <= bus.we_i;
            count_q   <= CNT_INIT;
            if (LATENCY == 1) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
              data_q  <= bus.we_i ? 32'd0 : memArray[wordIdx_d];
            end else begin
              state_q <= ST_WAIT;
              ack_q   <= 1'b0;
              data_q  <= 32'd0;
            end
          end else begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            data_q  <= 32'd0;
          end
        end

        // Request inputs are ignored here; the latched request always completes.
        ST_WAIT: begin
          if (count_q <= 4'd1) begin
            count_q <= 4'd0;
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
            data_q  <= isWrite_q ? 32'd0 : memArray[wordIdx_q];
          end else begin
            count_q <= count_q - 4'd1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          count_q <= 4'd0;
          ack_q   <= 1'b0;
          data_q  <= 32'd0;
        end
      endcase
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.data_o     = data_q;
  assign bus.resp_state = state_q;

endmodule
